// File: rtl/idex_exmem_ctrl_pipe.sv
// Purpose: holds the 17-bit control word across ID/EX and EX/MEM, slices per-stage fields, and computes nPC+4 (optional IDEX_FLUSH_EN adds a bubble-insert input).
// Latency: ID word appears on ex_* one edge later and on mem_* two edges later; adder_out is combinational.
// Backpressure: none. A new word is accepted every cycle, with no stall or handshake.
module idex_exmem_ctrl_pipe (
    input  logic        clk,
    input  logic        reset,
`ifdef IDEX_FLUSH_EN
    input  logic        idex_flush,
`endif
    input  logic [31:0] adder_in,
    output logic [31:0] adder_out,
    input  logic [16:0] id_control_signals,
    output logic [16:0] ex_control_signals,
    output logic [2:0]  ex_alu_op,
    output logic [2:0]  ex_source_operand,
    output logic        ex_branch_instr,
    output logic        ex_load_instr,
    output logic        ex_rf_enable,
    output logic [16:0] mem_control_signals,
    output logic [1:0]  mem_size,
    output logic        mem_rw,
    output logic        mem_se,
    output logic        mem_enable,
    output logic        mem_load_instr,
    output logic        mem_rf_enable
);

    logic [16:0] ex_q;
    logic [16:0] mem_q;

    // ID/EX stage register: reset wins, then the optional bubble, else capture the ID word
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end
`ifdef IDEX_FLUSH_EN
        else if (idex_flush) begin
            ex_q <= '0;
        end
`endif
        else begin
            ex_q <= id_control_signals;
        end
    end

    // EX/MEM stage register: forwards the whole ID/EX word, including fields EX already used
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= ex_q;
        end
    end

    // nPC + 4, wraps modulo 2^32 with carry-out dropped
    assign adder_out = adder_in + 32'd4;

    assign ex_control_signals  = ex_q;
    assign ex_source_operand   = ex_q[16:14];
    assign ex_alu_op           = ex_q[13:11];
    assign ex_load_instr       = ex_q[10];
    assign ex_rf_enable        = ex_q[9];
    assign ex_branch_instr     = ex_q[8];

    assign mem_control_signals = mem_q;
    assign mem_load_instr      = mem_q[10];
    assign mem_rf_enable       = mem_q[9];
    assign mem_size            = mem_q[6:5];
    assign mem_rw              = mem_q[4];
    assign mem_se              = mem_q[3];
    assign mem_enable          = mem_q[0];

endmodule

// File: tb/tb_idex_exmem_ctrl_pipe.sv
// Purpose: directed-vector bench for idex_exmem_ctrl_pipe (IDEX_FLUSH_EN section compiled only when defined).
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_idex_exmem_ctrl_pipe;

    logic        clk = 1'b0;
    logic        reset;
`ifdef IDEX_FLUSH_EN
    logic        idex_flush;
`endif
    logic [31:0] adder_in;
    logic [31:0] adder_out;
    logic [16:0] id_control_signals;
    logic [16:0] ex_control_signals;
    logic [2:0]  ex_alu_op;
    logic [2:0]  ex_source_operand;
    logic        ex_branch_instr;
    logic        ex_load_instr;
    logic        ex_rf_enable;
    logic [16:0] mem_control_signals;
    logic [1:0]  mem_size;
    logic        mem_rw;
    logic        mem_se;
    logic        mem_enable;
    logic        mem_load_instr;
    logic        mem_rf_enable;

    int checks = 0;
    int errors = 0;

    idex_exmem_ctrl_pipe dut (
        .clk                 (clk),
        .reset               (reset),
`ifdef IDEX_FLUSH_EN
        .idex_flush          (idex_flush),
`endif
        .adder_in            (adder_in),
        .adder_out           (adder_out),
        .id_control_signals  (id_control_signals),
        .ex_control_signals  (ex_control_signals),
        .ex_alu_op           (ex_alu_op),
        .ex_source_operand   (ex_source_operand),
        .ex_branch_instr     (ex_branch_instr),
        .ex_load_instr       (ex_load_instr),
        .ex_rf_enable        (ex_rf_enable),
        .mem_control_signals (mem_control_signals),
        .mem_size            (mem_size),
        .mem_rw              (mem_rw),
        .mem_se              (mem_se),
        .mem_enable          (mem_enable),
        .mem_load_instr      (mem_load_instr),
        .mem_rf_enable       (mem_rf_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // expected value of a multi-bit field [hi:lo] when only bit idx of the word is set
    function automatic logic [31:0] onehot_field(input int idx, input int lo, input int hi);
        if (idx >= lo && idx <= hi) return 32'(1) << (idx - lo);
        return 32'd0;
    endfunction

    localparam logic [16:0] LAT_WORD = 17'b001_010_1_1_0_0_10_0_1_0_0_1;

    initial begin
        logic [16:0] w;
        reset = 1'b1;
        id_control_signals = 17'h1FFFF;
        adder_in = 32'd0;
`ifdef IDEX_FLUSH_EN
        idex_flush = 1'b0;
`endif
        // reset state
        step();
        chk("rst_ex", 32'(ex_control_signals), 32'd0);
        chk("rst_mem", 32'(mem_control_signals), 32'd0);
        chk("rst_ex_alu", 32'(ex_alu_op), 32'd0);
        chk("rst_ex_src", 32'(ex_source_operand), 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd0);
        chk("rst_mem_en", 32'(mem_enable), 32'd0);

        // pipeline latency
        reset = 1'b0;
        id_control_signals = LAT_WORD;
        step();
        chk("lat_ex_word", 32'(ex_control_signals), 32'h05649);
        chk("lat_ex_alu", 32'(ex_alu_op), 32'd2);
        chk("lat_ex_src", 32'(ex_source_operand), 32'd1);
        chk("lat_ex_load", 32'(ex_load_instr), 32'd1);
        chk("lat_ex_rf", 32'(ex_rf_enable), 32'd1);
        chk("lat_ex_br", 32'(ex_branch_instr), 32'd0);
        chk("lat_mem_pre", 32'(mem_control_signals), 32'd0);
        id_control_signals = 17'd0;
        step();
        chk("lat_mem_size", 32'(mem_size), 32'd2);
        chk("lat_mem_se", 32'(mem_se), 32'd1);
        chk("lat_mem_en", 32'(mem_enable), 32'd1);
        chk("lat_mem_rw", 32'(mem_rw), 32'd0);
        chk("lat_mem_load", 32'(mem_load_instr), 32'd1);
        chk("lat_mem_rf", 32'(mem_rf_enable), 32'd1);
        chk("lat_mem_word", 32'(mem_control_signals), 32'h05649);
        chk("lat_ex_clear", 32'(ex_control_signals), 32'd0);

        // field isolation with one-hot words
        for (int i = 0; i < 17; i++) begin
            w = 17'd1 << i;
            id_control_signals = w;
            step();
            chk($sformatf("iso%0d_ex_word", i), 32'(ex_control_signals), 32'(w));
            chk($sformatf("iso%0d_ex_src", i), 32'(ex_source_operand), onehot_field(i, 14, 16));
            chk($sformatf("iso%0d_ex_alu", i), 32'(ex_alu_op), onehot_field(i, 11, 13));
            chk($sformatf("iso%0d_ex_load", i), 32'(ex_load_instr), 32'(i == 10));
            chk($sformatf("iso%0d_ex_rf", i), 32'(ex_rf_enable), 32'(i == 9));
            chk($sformatf("iso%0d_ex_br", i), 32'(ex_branch_instr), 32'(i == 8));
            id_control_signals = 17'd0;
            step();
            chk($sformatf("iso%0d_ex_zero", i), 32'(ex_control_signals), 32'd0);
            chk($sformatf("iso%0d_mem_word", i), 32'(mem_control_signals), 32'(w));
            chk($sformatf("iso%0d_mem_load", i), 32'(mem_load_instr), 32'(i == 10));
            chk($sformatf("iso%0d_mem_rf", i), 32'(mem_rf_enable), 32'(i == 9));
            chk($sformatf("iso%0d_mem_size", i), 32'(mem_size), onehot_field(i, 5, 6));
            chk($sformatf("iso%0d_mem_rw", i), 32'(mem_rw), 32'(i == 4));
            chk($sformatf("iso%0d_mem_se", i), 32'(mem_se), 32'(i == 3));
            chk($sformatf("iso%0d_mem_en", i), 32'(mem_enable), 32'(i == 0));
        end

        // adder, including wrap
        adder_in = 32'd0;          #1; chk("add_0", adder_out, 32'd4);
        adder_in = 32'd4;          #1; chk("add_4", adder_out, 32'd8);
        adder_in = 32'h0000_01FC;  #1; chk("add_1fc", adder_out, 32'h0000_0200);
        adder_in = 32'hFFFF_FFFC;  #1; chk("add_wrap", adder_out, 32'h0000_0000);
        adder_in = 32'h1234_5678;  #1; chk("add_mid", adder_out, 32'h1234_567C);

        // mid-stream reset
        id_control_signals = 17'h1FFFF;
        step();
        step();
        chk("mrst_pre_ex", 32'(ex_control_signals), 32'h1FFFF);
        chk("mrst_pre_mem", 32'(mem_control_signals), 32'h1FFFF);
        reset = 1'b1;
        step();
        chk("mrst_ex", 32'(ex_control_signals), 32'd0);
        chk("mrst_mem", 32'(mem_control_signals), 32'd0);
        chk("mrst_mem_size", 32'(mem_size), 32'd0);
        reset = 1'b0;
        id_control_signals = LAT_WORD;
        step();
        chk("post_rst_ex", 32'(ex_control_signals), 32'h05649);
        chk("post_rst_mem", 32'(mem_control_signals), 32'd0);

`ifdef IDEX_FLUSH_EN
        // bubble insertion
        id_control_signals = 17'h00200;
        step();
        step();
        chk("fl_pre_ex", 32'(ex_control_signals), 32'h00200);
        idex_flush = 1'b1;
        step();
        chk("fl_ex", 32'(ex_control_signals), 32'd0);
        chk("fl_mem", 32'(mem_control_signals), 32'h00200);
        idex_flush = 1'b0;
        step();
        chk("fl_mem_bubble", 32'(mem_control_signals), 32'd0);
        chk("fl_ex_resume", 32'(ex_control_signals), 32'h00200);
        // reset overrides flush
        idex_flush = 1'b1;
        reset = 1'b1;
        step();
        chk("fl_rst_ex", 32'(ex_control_signals), 32'd0);
        chk("fl_rst_mem", 32'(mem_control_signals), 32'd0);
        idex_flush = 1'b0;
        reset = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
